// File: rtl/kftvga_text_pkg.sv
// Shared types and widths for the KFTVGA text console front-end.
// Command/state encodings, default geometry and bus address widths.
package kftvga_text_pkg;

   localparam int DEF_COLUMNS = 80;
   localparam int DEF_ROWS    = 60;

   localparam int COL_W  = 7;
   localparam int ROW_W  = 6;
   localparam int CELL_W = 13;
   localparam int ADDR_W = 14;

   typedef enum logic [1:0] {
      CMD_PUT        = 2'b00,
      CMD_SET_CURSOR = 2'b01,
      CMD_CLEAR      = 2'b10,
      CMD_NEWLINE    = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHAR_WR,
      ST_CHAR_HOLD,
      ST_ATTR_WR,
      ST_ATTR_HOLD
   } state_e;

endpackage

// File: rtl/kftvga_cursor.sv
// Cursor keeper: separate col/row registers with wrap, clamp and newline,
// plus the registered linear cell index row*COLUMNS+col.
module kftvga_cursor
   import kftvga_text_pkg::*;
#(
   parameter int COLUMNS = DEF_COLUMNS,
   parameter int ROWS    = DEF_ROWS
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              home,
   input  logic              set_en,
   input  logic [COL_W-1:0]  set_col,
   input  logic [ROW_W-1:0]  set_row,
   input  logic              newline,
   input  logic              advance,
   output logic [CELL_W-1:0] cursor
);

   localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLUMNS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
   localparam logic [CELL_W-1:0] COLS_C   = CELL_W'(COLUMNS);

   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [CELL_W-1:0] cursor_q, cursor_d;
   logic [ROW_W-1:0]  row_inc;

   assign row_inc = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      unique case (1'b1)
         home: begin
            col_d = '0;
            row_d = '0;
         end
         set_en: begin
            col_d = (set_col > LAST_COL) ? LAST_COL : set_col;
            row_d = (set_row > LAST_ROW) ? LAST_ROW : set_row;
         end
         newline: begin
            col_d = '0;
            row_d = row_inc;
         end
         advance: begin
            if (col_q == LAST_COL) begin
               col_d = '0;
               row_d = row_inc;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Index is built from the next col/row so it lands on the same edge.
   assign cursor_d = CELL_W'(row_d) * COLS_C + CELL_W'(col_d);

   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         col_q    <= '0;
         row_q    <= '0;
         cursor_q <= '0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         cursor_q <= cursor_d;
      end
   end

   assign cursor = cursor_q;

endmodule

// File: rtl/kftvga_text_writer.sv
// Text console command sequencer driving the KFTVGA byte-wide host bus.
// Optional full-screen clear when KFTVGA_TEXT_WRITER_CLEAR_EN is defined.
module kftvga_text_writer
   import kftvga_text_pkg::*;
#(
   parameter int COLUMNS = DEF_COLUMNS,
   parameter int ROWS    = DEF_ROWS
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_cmd,
   input  logic [7:0]        req_char,
   input  logic [7:0]        req_color,
   input  logic [COL_W-1:0]  req_col,
   input  logic [ROW_W-1:0]  req_row,
   output logic              busy,
   output logic [CELL_W-1:0] cursor,
   output logic              chip_select_n,
   output logic              write_enable_n,
   output logic              read_enable_n,
   output logic [ADDR_W-1:0] address,
   output logic [7:0]        write_data
);

   state_e            state_q, state_d;
   logic              cs_n_q, cs_n_d;
   logic              we_n_q, we_n_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        color_q, color_d;
   logic              home, set_en, newline, advance;

`ifdef KFTVGA_TEXT_WRITER_CLEAR_EN
   localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(COLUMNS * ROWS - 1);
   logic              clearing_q, clearing_d;
   logic [CELL_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [CELL_W-1:0] clr_nxt;
   assign clr_nxt = clr_cnt_q + 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      cs_n_d  = 1'b1;
      we_n_d  = 1'b1;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      color_d = color_q;
      home    = 1'b0;
      set_en  = 1'b0;
      newline = 1'b0;
      advance = 1'b0;
`ifdef KFTVGA_TEXT_WRITER_CLEAR_EN
      clearing_d = clearing_q;
      clr_cnt_d  = clr_cnt_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               unique case (cmd_e'(req_cmd))
                  CMD_PUT: begin
                     color_d = req_color;
                     state_d = ST_CHAR_WR;
                     cs_n_d  = 1'b0;
                     we_n_d  = 1'b0;
                     addr_d  = {cursor, 1'b0};
                     wdata_d = req_char;
                  end
                  CMD_SET_CURSOR: set_en  = 1'b1;
                  CMD_NEWLINE:    newline = 1'b1;
                  CMD_CLEAR: begin
`ifdef KFTVGA_TEXT_WRITER_CLEAR_EN
                     clearing_d = 1'b1;
                     clr_cnt_d  = '0;
                     color_d    = req_color;
                     state_d    = ST_CHAR_WR;
                     cs_n_d     = 1'b0;
                     we_n_d     = 1'b0;
                     addr_d     = '0;
                     wdata_d    = 8'h00;
`endif
                  end
                  default: ;
               endcase
            end
         end
         ST_CHAR_WR: begin
            state_d = ST_CHAR_HOLD;
            cs_n_d  = 1'b0;
         end
         ST_CHAR_HOLD: begin
            state_d = ST_ATTR_WR;
            cs_n_d  = 1'b0;
            we_n_d  = 1'b0;
            addr_d  = {addr_q[ADDR_W-1:1], 1'b1};
            wdata_d = color_q;
         end
         ST_ATTR_WR: begin
            state_d = ST_ATTR_HOLD;
            cs_n_d  = 1'b0;
         end
         ST_ATTR_HOLD: begin
`ifdef KFTVGA_TEXT_WRITER_CLEAR_EN
            if (clearing_q) begin
               if (clr_cnt_q == LAST_CELL) begin
                  state_d    = ST_IDLE;
                  clearing_d = 1'b0;
                  home       = 1'b1;
               end else begin
                  clr_cnt_d = clr_nxt;
                  state_d   = ST_CHAR_WR;
                  cs_n_d    = 1'b0;
                  we_n_d    = 1'b0;
                  addr_d    = {clr_nxt, 1'b0};
                  wdata_d   = 8'h00;
               end
            end else begin
               state_d = ST_IDLE;
               advance = 1'b1;
            end
`else
            state_d = ST_IDLE;
            advance = 1'b1;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cs_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         cs_n_q  <= cs_n_d;
         we_n_q  <= we_n_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         color_q <= color_d;
      end
   end

`ifdef KFTVGA_TEXT_WRITER_CLEAR_EN
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clearing_q <= 1'b0;
         clr_cnt_q  <= '0;
      end else begin
         clearing_q <= clearing_d;
         clr_cnt_q  <= clr_cnt_d;
      end
   end
`endif

   kftvga_cursor #(
      .COLUMNS (COLUMNS),
      .ROWS    (ROWS)
   ) u_cursor (
      .clock   (clock),
      .reset_n (reset_n),
      .home    (home),
      .set_en  (set_en),
      .set_col (req_col),
      .set_row (req_row),
      .newline (newline),
      .advance (advance),
      .cursor  (cursor)
   );

   assign req_ready      = (state_q == ST_IDLE);
   assign busy           = (state_q != ST_IDLE);
   assign chip_select_n  = cs_n_q;
   assign write_enable_n = we_n_q;
   assign read_enable_n  = 1'b1;
   assign address        = addr_q;
   assign write_data     = wdata_q;

endmodule

// File: tb/tb_kftvga_text_writer.sv
// Directed bench for kftvga_text_writer; DUT acts on falling edges,
// bench drives and samples just after rising edges.
module tb_kftvga_text_writer;
   import kftvga_text_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_cmd = 2'b00;
   logic [7:0]  req_char = 8'h00;
   logic [7:0]  req_color = 8'h00;
   logic [6:0]  req_col = 7'd0;
   logic [5:0]  req_row = 6'd0;
   logic        busy;
   logic [12:0] cursor;
   logic        chip_select_n, write_enable_n, read_enable_n;
   logic [13:0] address;
   logic [7:0]  write_data;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   kftvga_text_writer dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_cmd        (req_cmd),
      .req_char       (req_char),
      .req_color      (req_color),
      .req_col        (req_col),
      .req_row        (req_row),
      .busy           (busy),
      .cursor         (cursor),
      .chip_select_n  (chip_select_n),
      .write_enable_n (write_enable_n),
      .read_enable_n  (read_enable_n),
      .address        (address),
      .write_data     (write_data)
   );

   function automatic logic [25:0] obs();
      return {busy, req_ready, chip_select_n, write_enable_n, address, write_data};
   endfunction

   function automatic logic [25:0] ev(logic b, logic r, logic cs, logic we,
                                      logic [13:0] a, logic [7:0] d);
      return {b, r, cs, we, a, d};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [1:0] cmd, input logic [7:0] ch,
                        input logic [7:0] col8, input logic [6:0] c,
                        input logic [5:0] r);
      @(posedge clock);
      #1;
      req_valid = 1'b1;
      req_cmd   = cmd;
      req_char  = ch;
      req_color = col8;
      req_col   = c;
      req_row   = r;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 50 && !req_ready; i++) step();
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL wait_ready timeout ready=%b required=1", req_ready);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (obs() !== ev(0, 1, 1, 1, 14'd0, 8'd0)) begin
         failures++;
         $display("FAIL reset_bus got=%h required=%h", obs(), ev(0, 1, 1, 1, 14'd0, 8'd0));
      end
      checks++;
      if ({read_enable_n, cursor} !== {1'b1, 13'd0}) begin
         failures++;
         $display("FAIL reset_cursor got re=%b cur=%0d required re=1 cur=0",
                  read_enable_n, cursor);
      end
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_put();
      logic [25:0] e[5];
      e[0] = ev(1, 0, 0, 0, 14'd0, 8'd72);
      e[1] = ev(1, 0, 0, 1, 14'd0, 8'd72);
      e[2] = ev(1, 0, 0, 0, 14'd1, 8'h0F);
      e[3] = ev(1, 0, 0, 1, 14'd1, 8'h0F);
      e[4] = ev(0, 1, 1, 1, 14'd1, 8'h0F);
      issue(CMD_PUT, 8'd72, 8'h0F, 7'd0, 6'd0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         checks++;
         if (obs() !== e[i]) begin
            failures++;
            $display("FAIL put_cycle%0d got=%h required=%h", i, obs(), e[i]);
         end
      end
      checks++;
      if (cursor !== 13'd1) begin
         failures++;
         $display("FAIL put_cursor got=%0d required=1", cursor);
      end
   endtask

   task automatic test_wrap();
      logic [25:0] e[5];
      e[0] = ev(1, 0, 0, 0, 14'd9598, 8'd65);
      e[1] = ev(1, 0, 0, 1, 14'd9598, 8'd65);
      e[2] = ev(1, 0, 0, 0, 14'd9599, 8'h1E);
      e[3] = ev(1, 0, 0, 1, 14'd9599, 8'h1E);
      e[4] = ev(0, 1, 1, 1, 14'd9599, 8'h1E);
      issue(CMD_SET_CURSOR, 8'd0, 8'd0, 7'd79, 6'd59);
      checks++;
      if (cursor !== 13'd4799) begin
         failures++;
         $display("FAIL wrap_set got=%0d required=4799", cursor);
      end
      issue(CMD_PUT, 8'd65, 8'h1E, 7'd0, 6'd0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         checks++;
         if (obs() !== e[i]) begin
            failures++;
            $display("FAIL wrap_cycle%0d got=%h required=%h", i, obs(), e[i]);
         end
      end
      checks++;
      if (cursor !== 13'd0) begin
         failures++;
         $display("FAIL wrap_cursor got=%0d required=0", cursor);
      end
   endtask

   task automatic test_newline();
      issue(CMD_SET_CURSOR, 8'd0, 8'd0, 7'd10, 6'd3);
      checks++;
      if (cursor !== 13'd250) begin
         failures++;
         $display("FAIL nl_set got=%0d required=250", cursor);
      end
      issue(CMD_NEWLINE, 8'd0, 8'd0, 7'd0, 6'd0);
      for (int i = 0; i < 2; i++) begin
         if (i > 0) step();
         checks++;
         if ({obs(), cursor} !== {ev(0, 1, 1, 1, 14'd9599, 8'h1E), 13'd320}) begin
            failures++;
            $display("FAIL nl_row%0d got bus=%h cur=%0d required bus=%h cur=320",
                     i, obs(), cursor, ev(0, 1, 1, 1, 14'd9599, 8'h1E));
         end
      end
      issue(CMD_SET_CURSOR, 8'd0, 8'd0, 7'd7, 6'd59);
      issue(CMD_NEWLINE, 8'd0, 8'd0, 7'd0, 6'd0);
      checks++;
      if (cursor !== 13'd0) begin
         failures++;
         $display("FAIL nl_wrap got=%0d required=0", cursor);
      end
   endtask

   task automatic test_clamp();
      logic [6:0]  c[3];
      logic [5:0]  r[3];
      logic [12:0] e[3];
      c[0] = 7'd127; r[0] = 6'd63; e[0] = 13'd4799;
      c[1] = 7'd100; r[1] = 6'd2;  e[1] = 13'd239;
      c[2] = 7'd5;   r[2] = 6'd63; e[2] = 13'd4725;
      for (int i = 0; i < 3; i++) begin
         issue(CMD_SET_CURSOR, 8'd0, 8'd0, c[i], r[i]);
         checks++;
         if (cursor !== e[i]) begin
            failures++;
            $display("FAIL clamp%0d got=%0d required=%0d", i, cursor, e[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [25:0] e[6];
      e[0] = ev(1, 0, 0, 0, 14'd160, 8'h31);
      e[1] = ev(1, 0, 0, 1, 14'd160, 8'h31);
      e[2] = ev(1, 0, 0, 0, 14'd161, 8'h02);
      e[3] = ev(1, 0, 0, 1, 14'd161, 8'h02);
      e[4] = ev(0, 1, 1, 1, 14'd161, 8'h02);
      e[5] = ev(1, 0, 0, 0, 14'd162, 8'h31);
      issue(CMD_SET_CURSOR, 8'd0, 8'd0, 7'd0, 6'd1);
      @(posedge clock);
      #1;
      req_valid = 1'b1;
      req_cmd   = CMD_PUT;
      req_char  = 8'h31;
      req_color = 8'h02;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (obs() !== e[i]) begin
            failures++;
            $display("FAIL b2b_cycle%0d got=%h required=%h", i, obs(), e[i]);
         end
      end
      req_valid = 1'b0;
      wait_ready();
      checks++;
      if (cursor !== 13'd82) begin
         failures++;
         $display("FAIL b2b_cursor got=%0d required=82", cursor);
      end
   endtask

   task automatic test_clear();
`ifdef KFTVGA_TEXT_WRITER_CLEAR_EN
      int cyc = 0;
      int strobes = 0;
      int bad = 0;
      logic [13:0] last = '0;
      issue(CMD_CLEAR, 8'd0, 8'h07, 7'd0, 6'd0);
      while (busy && cyc < 20000) begin
         cyc++;
         if (!write_enable_n) begin
            strobes++;
            last = address;
            if (write_data !== (address[0] ? 8'h07 : 8'h00)) bad++;
         end
         step();
      end
      checks++;
      if (cyc != 19200) begin
         failures++;
         $display("FAIL clear_busy got=%0d required=19200", cyc);
      end
      checks++;
      if (strobes != 9600) begin
         failures++;
         $display("FAIL clear_strobes got=%0d required=9600", strobes);
      end
      checks++;
      if ({last, bad} !== {14'd9599, 32'd0}) begin
         failures++;
         $display("FAIL clear_last got addr=%0d bad=%0d required addr=9599 bad=0",
                  last, bad);
      end
      checks++;
      if ({req_ready, cursor} !== {1'b1, 13'd0}) begin
         failures++;
         $display("FAIL clear_cursor got rdy=%b cur=%0d required rdy=1 cur=0",
                  req_ready, cursor);
      end
`else
      issue(CMD_CLEAR, 8'd0, 8'h07, 7'd0, 6'd0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step();
         checks++;
         if ({obs(), cursor} !== {ev(0, 1, 1, 1, 14'd163, 8'h02), 13'd82}) begin
            failures++;
            $display("FAIL clear_noop%0d got bus=%h cur=%0d required bus=%h cur=82",
                     i, obs(), cursor, ev(0, 1, 1, 1, 14'd163, 8'h02));
         end
      end
`endif
   endtask

   task automatic test_reset_mid();
      issue(CMD_SET_CURSOR, 8'd0, 8'd0, 7'd5, 6'd0);
      issue(CMD_PUT, 8'd90, 8'h22, 7'd0, 6'd0);
      step();
      step();
      checks++;
      if (obs() !== ev(1, 0, 0, 0, 14'd11, 8'h22)) begin
         failures++;
         $display("FAIL rst_attr_wr got=%h required=%h", obs(), ev(1, 0, 0, 0, 14'd11, 8'h22));
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({obs(), cursor} !== {ev(0, 1, 1, 1, 14'd0, 8'd0), 13'd0}) begin
         failures++;
         $display("FAIL rst_mid got bus=%h cur=%0d required bus=%h cur=0",
                  obs(), cursor, ev(0, 1, 1, 1, 14'd0, 8'd0));
      end
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      issue(CMD_PUT, 8'd90, 8'h22, 7'd0, 6'd0);
      checks++;
      if (obs() !== ev(1, 0, 0, 0, 14'd0, 8'd90)) begin
         failures++;
         $display("FAIL rst_next_put got=%h required=%h", obs(), ev(1, 0, 0, 0, 14'd0, 8'd90));
      end
      wait_ready();
      checks++;
      if (cursor !== 13'd1) begin
         failures++;
         $display("FAIL rst_next_cursor got=%0d required=1", cursor);
      end
   endtask

   initial begin
      test_reset();
      test_put();
      test_wrap();
      test_newline();
      test_clamp();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
